// File: rtl/btn_sched_pkg.sv
// Shared types and constants for the button event scheduler.
package btn_sched_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } sched_state_e;

    localparam int unsigned DEB_W  = 20;
    localparam int unsigned HOLD_W = 24;

    localparam logic [DEB_W-1:0]  DEB_CYCLES_DEF  = 20'd500000;
    localparam logic [HOLD_W-1:0] LONG_CYCLES_DEF = 24'd5000000;

    // Width of a button index; never below one bit so a single button still has a port.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_edge.sv
// One button: 2-FF synchronizer, debounce counter, debounced level and press pulse.
// With BTN_LONG_PRESS_EN defined it also owns the long-press hold counter.
module btn_debounce_edge
    import btn_sched_pkg::*;
#(
    parameter logic [DEB_W-1:0] DEB_CYCLES = DEB_CYCLES_DEF
`ifdef BTN_LONG_PRESS_EN
    ,
    parameter logic [HOLD_W-1:0] LONG_CYCLES = LONG_CYCLES_DEF
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic press,
    output logic long_press
);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             armed;
    logic [1:0]       flush;
    logic [DEB_W-1:0] cnt;
    logic             differ_c;
    logic             settle_c;

    assign differ_c = (sync2 != deb);
    assign settle_c = differ_c && (cnt == DEB_CYCLES - DEB_W'(1));

    // A press only counts once the button has been seen released after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            deb   <= 1'b1;
            armed <= 1'b0;
            flush <= 2'b00;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            flush <= {flush[0], 1'b1};
            if (flush[1] && sync2) begin
                armed <= 1'b1;
            end
            press <= settle_c && !sync2 && armed;
            if (!differ_c) begin
                cnt <= '0;
            end else if (settle_c) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + DEB_W'(1);
            end
        end
    end

`ifdef BTN_LONG_PRESS_EN
    logic              hold_run;
    logic [HOLD_W-1:0] hold_cnt;

    // One long pulse per press; a release stops the count and re-arms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_run   <= 1'b0;
            hold_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (deb) begin
                hold_run <= 1'b0;
                hold_cnt <= '0;
            end else if (press) begin
                hold_run <= 1'b1;
                hold_cnt <= '0;
            end else if (hold_run) begin
                if (hold_cnt == LONG_CYCLES - HOLD_W'(1)) begin
                    long_press <= 1'b1;
                    hold_run   <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/button_event_sched.sv
// Debounced button presses queued per button and served round-robin over valid/ready.
// Optional long-press events are enabled with BTN_LONG_PRESS_EN.
module button_event_sched
    import btn_sched_pkg::*;
#(
    parameter int unsigned      N_BTN      = 4,
    parameter logic [DEB_W-1:0] DEB_CYCLES = DEB_CYCLES_DEF
`ifdef BTN_LONG_PRESS_EN
    ,
    parameter logic [HOLD_W-1:0] LONG_CYCLES = LONG_CYCLES_DEF
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         button,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [id_w(N_BTN)-1:0]   evt_id,
    output logic                     evt_long,
    output logic [N_BTN-1:0]         evt_drop,
    input  logic                     drop_clr
);

    localparam int unsigned ID_W = id_w(N_BTN);

    sched_state_e      state;
    sched_state_e      state_nx;
    logic [N_BTN-1:0]  btn_press;
    logic [N_BTN-1:0]  btn_long;
    logic [N_BTN-1:0]  pending;
    logic [N_BTN-1:0]  long_pend;
    logic [N_BTN-1:0]  pending_nx;
    logic [N_BTN-1:0]  long_pend_nx;
    logic [N_BTN-1:0]  drop_nx;
    logic [ID_W-1:0]   rr;
    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic              pick_long;
    logic              load_c;
    logic              accept_c;

    for (genvar g = 0; g < int'(N_BTN); g++) begin : g_btn
        btn_debounce_edge #(
            .DEB_CYCLES  (DEB_CYCLES)
`ifdef BTN_LONG_PRESS_EN
            ,
            .LONG_CYCLES (LONG_CYCLES)
`endif
        ) u_deb (
            .clk        (clk),
            .rst_n      (rst_n),
            .button     (button[g]),
            .press      (btn_press[g]),
            .long_press (btn_long[g])
        );
    end

    // First requesting button at or after rr; descending scan so the nearest wins.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        pick_long  = 1'b0;
        for (int j = int'(N_BTN) - 1; j >= 0; j--) begin
            int              k;
            logic [ID_W-1:0] idx;
            k = int'(rr) + j;
            if (k >= int'(N_BTN)) begin
                k = k - int'(N_BTN);
            end
            idx = ID_W'(k);
            if (pending[idx] || long_pend[idx]) begin
                pick_found = 1'b1;
                pick_id    = idx;
                pick_long  = !pending[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (pick_found) state_nx = S_OFFER;
            S_OFFER: if (evt_ready)  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        load_c   = (state == S_IDLE) && pick_found;
        accept_c = (state == S_OFFER) && evt_valid && evt_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_long  <= 1'b0;
            rr        <= '0;
        end else if (load_c) begin
            evt_valid <= 1'b1;
            evt_id    <= pick_id;
            evt_long  <= pick_long;
        end else if (accept_c) begin
            evt_valid <= 1'b0;
            rr        <= (evt_id == ID_W'(N_BTN - 1)) ? '0 : evt_id + ID_W'(1);
        end
    end

    // Accept clears first so a same-cycle press of the accepted button is kept.
    always_comb begin
        pending_nx   = pending;
        long_pend_nx = long_pend;
        drop_nx      = drop_clr ? '0 : evt_drop;
        if (accept_c) begin
            if (evt_long) long_pend_nx[evt_id] = 1'b0;
            else          pending_nx[evt_id]   = 1'b0;
        end
        for (int i = 0; i < int'(N_BTN); i++) begin
            if (btn_press[i]) begin
                if (pending_nx[i]) drop_nx[i]    = 1'b1;
                else               pending_nx[i] = 1'b1;
            end
            if (btn_long[i]) begin
                if (long_pend_nx[i]) drop_nx[i]      = 1'b1;
                else                 long_pend_nx[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            long_pend <= '0;
            evt_drop  <= '0;
        end else begin
            pending   <= pending_nx;
            long_pend <= long_pend_nx;
            evt_drop  <= drop_nx;
        end
    end

endmodule

// File: tb/tb_button_event_sched.sv
// Directed bench for button_event_sched (N_BTN=4, DEB_CYCLES=4, LONG_CYCLES=16).
// Long-press expectations follow BTN_LONG_PRESS_EN.
module tb_button_event_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] button;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_long;
    logic [3:0] evt_drop;
    logic       drop_clr;

    int n_chk  = 0;
    int n_pass = 0;

    button_event_sched #(
        .N_BTN       (4),
        .DEB_CYCLES  (20'd4)
`ifdef BTN_LONG_PRESS_EN
        ,
        .LONG_CYCLES (24'd16)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .button    (button),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_long  (evt_long),
        .evt_drop  (evt_drop),
        .drop_clr  (drop_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        button    = 4'hF;
        evt_ready = 1'b1;
        drop_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_evt(input int budget, output logic ok, output int id,
                            output logic lng, output int waited);
        ok = 1'b0; id = -1; lng = 1'b0; waited = 0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            waited++;
            if (evt_valid) begin
                ok  = 1'b1;
                id  = int'(evt_id);
                lng = evt_long;
                break;
            end
        end
    endtask

    task automatic count_evts(input int n, output int nv);
        nv = 0;
        for (int c = 0; c < n; c++) begin
            tick(1);
            if (evt_valid) nv++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        int   id;
        logic lng;
        int   waited;
        int   nv;
        int   n_norm;
        int   n_long;
        int   n_other;
        logic first_long;

        // Reset values while rst_n is low
        rst_n     = 1'b0;
        button    = 4'hF;
        evt_ready = 1'b1;
        drop_clr  = 1'b0;
        #1;
        check("rst_valid", evt_valid, 0);
        check("rst_id", evt_id, 0);
        check("rst_long", evt_long, 0);
        check("rst_drop", evt_drop, 0);
        do_reset();

        // 1: button 2 driven low after edge 10 -> evt_valid exactly at edge 18
        tick(10);
        button[2] = 1'b0;
        tick(7);
        check("t1_valid_e17", evt_valid, 0);
        tick(1);
        check("t1_valid_e18", evt_valid, 1);
        check("t1_id", evt_id, 2);
        check("t1_long", evt_long, 0);
        tick(1);
        check("t1_valid_e19", evt_valid, 0);
        count_evts(8, nv);
        check("t1_no_second", nv, 0);
        button[2] = 1'b1;
        tick(12);

        // 2: a 3-cycle glitch is one cycle short of the debounce window
        button[1] = 1'b0;
        tick(3);
        button[1] = 1'b1;
        count_evts(15, nv);
        check("t2_no_event", nv, 0);
        check("t2_drop", evt_drop, 0);

        // 3: simultaneous presses served round-robin from pointer 0
        do_reset();
        tick(5);
        button = 4'b0100;
        wait_evt(20, ok, id, lng, waited);
        check("t3_a_seen", ok, 1);
        check("t3_a_id", id, 0);
        wait_evt(5, ok, id, lng, waited);
        check("t3_b_id", id, 1);
        check("t3_b_gap", waited, 2);
        wait_evt(5, ok, id, lng, waited);
        check("t3_c_id", id, 3);
        check("t3_c_gap", waited, 2);
        button = 4'hF;
        tick(12);
        button = 4'b0110;
        wait_evt(20, ok, id, lng, waited);
        check("t3_d_id", id, 0);
        wait_evt(5, ok, id, lng, waited);
        check("t3_e_id", id, 3);
        count_evts(6, nv);
        check("t3_drained", nv, 0);
        button = 4'hF;
        tick(12);

        // 4: second press of button 1 while its event is stalled is dropped
        evt_ready = 1'b0;
        button[1] = 1'b0;
        wait_evt(20, ok, id, lng, waited);
        check("t4_id", id, 1);
        button[1] = 1'b1;
        tick(10);
        button[1] = 1'b0;
        tick(12);
        check("t4_drop", evt_drop, 4'b0010);
        check("t4_held_valid", evt_valid, 1);
        check("t4_held_id", evt_id, 1);
        evt_ready = 1'b1;
        tick(1);
        check("t4_accepted", evt_valid, 0);
        count_evts(12, nv);
        check("t4_empty", nv, 0);
        check("t4_drop_sticky", evt_drop, 4'b0010);
        drop_clr = 1'b1;
        tick(1);
        drop_clr = 1'b0;
        check("t4_drop_clr", evt_drop, 0);
        button[1] = 1'b1;
        tick(10);

        // 5: reset mid-offer with button 0 held low through reset
        evt_ready = 1'b0;
        button[0] = 1'b0;
        wait_evt(20, ok, id, lng, waited);
        check("t5_offer_id", id, 0);
        #3 rst_n = 1'b0;
        #1;
        check("t5_async_valid", evt_valid, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        evt_ready = 1'b1;
        count_evts(30, nv);
        check("t5_held_no_evt", nv, 0);
        button[0] = 1'b1;
        tick(10);
        button[0] = 1'b0;
        wait_evt(20, ok, id, lng, waited);
        check("t5_repress_seen", ok, 1);
        check("t5_repress_id", id, 0);
        button[0] = 1'b1;
        tick(10);

        // 6: hold button 3 for 40 cycles, then watch for stragglers
        n_norm = 0; n_long = 0; n_other = 0; first_long = 1'b1;
        button[3] = 1'b0;
        for (int c = 0; c < 70; c++) begin
            if (c == 40) button[3] = 1'b1;
            tick(1);
            if (evt_valid) begin
                if (evt_id != 2'd3)    n_other++;
                else if (evt_long)     n_long++;
                else                   n_norm++;
                if (n_norm + n_long + n_other == 1) first_long = evt_long;
            end
        end
        check("t6_normal_cnt", n_norm, 1);
        check("t6_other_id", n_other, 0);
        check("t6_first_is_normal", first_long, 0);
`ifdef BTN_LONG_PRESS_EN
        check("t6_long_cnt", n_long, 1);
`else
        check("t6_long_never", n_long, 0);
`endif
        check("t6_drop", evt_drop, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
